mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter for the single data read/write port of `memory`. It shares that port between the processor data port (requester 0) and a host-side agent (requester 1), such as the syscall handler or program loader that reads and writes memory for syscall arguments. Grants are round-robin, with an optional lock for multi-word transfers and a bounded hold counter that prevents starvation. The block sits between `processor`/host agent and `memory` inside `hex`, and adds no latency to the memory read path.

## Interface

Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grants to one locked requester while the other is waiting; legal range 1..255.

Ports. Widths follow `hex_pkg`: `waddr_t` is the word address, `data_t` is 32 bits. `N` in the port names is 0 or 1.
- `i_clk`  in  1  clock; everything is on the rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_pN_valid`  in  1  requester N has a request.
- `i_pN_we`  in  1  request is a write.
- `i_pN_addr`  in  waddr_t  word address.
- `i_pN_data`  in  data_t  write data.
- `i_pN_lock`  in  1  asks to keep the grant after this request.
- `o_pN_ready`  out  1  request accepted this cycle.
- `o_pN_rvalid`  out  1  read data valid for requester N.
- `o_pN_rdata`  out  data_t  read data.
- `o_m_valid`  out  1  memory request valid.
- `o_m_we`  out  1  memory write enable.
- `o_m_addr`  out  waddr_t  memory address.
- `o_m_data`  out  data_t  memory write data.
- `i_m_data`  in  data_t  memory read data; valid one cycle after a read request.

## Operation

- **Grant logic.** Grant is computed combinationally each cycle from the valids, `last` (the last granted requester) and `owner`/`hold_cnt`.
- **Round-robin.** If both requesters are valid and there is no active lock, the requester other than `last` wins. If only one is valid, it wins.
- **Lock.** When a granted request has `lock`=1, `owner` is set to that requester. While `owner` is set, the owner wins whenever it is valid. If the owner is not valid, the other requester may be granted, and `owner` is kept.
- **Lock release.** `owner` is cleared when the owner issues an accepted request with `lock`=0. It is also force-cleared when `hold_cnt` reaches `MAX_HOLD`.
- **Hold counter.** `hold_cnt` increments on each owner grant while the other requester is valid. It resets to 0 on any grant to the other requester and whenever `owner` clears. It is 8 bits wide and saturates.
- **Forced release.** When `hold_cnt` reaches `MAX_HOLD`, the next cycle grants the waiting requester, `owner` is cleared and `last` is updated.
- **Ready and memory drive.** `o_pN_ready` = granted. The memory outputs mux the granted requester's fields. `o_m_valid` = any grant.
- **Read return.** The `rd_tag` register stores {valid read, requester} for the accepted request. On the next cycle `o_pN_rvalid` is asserted for the tagged requester, with `o_pN_rdata` = `i_m_data`. `rdata` is driven to both requesters, but only the tagged one sees `rvalid`.
- **Writes** produce no `rvalid`.

## Timing

- **Reset values:** all `ready`, `rvalid` and `o_m_*` outputs are 0. `last` = 1 (so requester 0 wins the first contention). `owner` = none, `hold_cnt` = 0, `rd_tag` = invalid.
- **Grant latency:** 0 cycles; `ready` is in the same cycle as `valid`. Read latency is 1 cycle from acceptance. Throughput is one request per cycle, with back-to-back reads from alternating requesters.
- **Valid rule:** a requester holds `valid` and its fields stable until `ready`.
- **Simultaneous events:**
  - An owner's unlock request and a waiting requester in the same cycle: the owner is granted, and the other requester is granted next cycle.
  - A write followed by a read of the same address in the next cycle returns the new data, because memory writes occur at the edge.
- **Reset mid-operation:** an outstanding read's `rvalid` is suppressed. The lock and counter clear.
- **Idle cycle** (no valid): `last`, `owner` and `hold_cnt` are unchanged.

## Structure

- Add `arb_req_t` to `hex_pkg`: the packed struct {we, addr, data, lock}, used for both requester inputs. Add `MEM_ARB_MAX_HOLD` as the default constant.
- `mem_arbiter` is a single module with no submodules.
- It is instantiated in `hex` between `u_processor`'s `o_d_*` port and `u_memory`'s `i_d_*` port. The fetch port remains direct.

## Test plan

- **Reset and first contention:** both requesters read (addr 0x10 and 0x20) in the cycle after reset. Expected: p0 is granted first and `p0_rvalid` follows one cycle later with mem[0x10]; p1 is granted the next cycle.
- **Continuous contention:** both requesters valid for 6 cycles, no lock. Expected: grants alternate 0,1,0,1,0,1, and each `rvalid` goes to the correct requester with correct data.
- **Locked burst:** p1 locks a 4-word write burst to 0x100..0x103 while p0 is idle. Expected: four consecutive p1 grants; p0 asserting valid at the third word waits until the unlock word is accepted.
- **Starvation bound:** `MAX_HOLD`=3, p0 holds `lock` permanently and p1 is valid. Expected: exactly 3 p0 grants, then a p1 grant, then p0 again.
- **Write then read:** p0 writes 0xDEADBEEF to 0x40, then p1 reads 0x40 in the next cycle. Expected: `p1_rdata` = 0xDEADBEEF.
- **Reset mid-read:** `i_rst` is asserted in the cycle after a p0 read is accepted. Expected: no `rvalid`, and all outputs are 0.

Source files
------------

// File: rtl/hex_pkg.sv
// Shared types and constants for the hex core: word address/data widths,
// the arbiter request bundle and the arbiter's default hold limit.
package hex_pkg;

  localparam int unsigned WADDR_W = 14;
  localparam int unsigned DATA_W  = 32;

  typedef logic [WADDR_W-1:0] waddr_t;
  typedef logic [DATA_W-1:0]  data_t;

  typedef struct packed {
    logic   we;
    waddr_t addr;
    data_t  data;
    logic   lock;
  } arb_req_t;

  localparam int unsigned MEM_ARB_MAX_HOLD = 8;

  typedef enum logic {
    REQ_P0 = 1'b0,
    REQ_P1 = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_P0) ? REQ_P1 : REQ_P0;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the memory data port between the processor (p0)
// and a host agent (p1), with lock, bounded hold and zero-latency grant.
module mem_arbiter
  import hex_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MEM_ARB_MAX_HOLD
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_p0_valid,
  input  logic               i_p0_we,
  input  logic [WADDR_W-1:0] i_p0_addr,
  input  logic [DATA_W-1:0]  i_p0_data,
  input  logic               i_p0_lock,
  output logic               o_p0_ready,
  output logic               o_p0_rvalid,
  output logic [DATA_W-1:0]  o_p0_rdata,
  input  logic               i_p1_valid,
  input  logic               i_p1_we,
  input  logic [WADDR_W-1:0] i_p1_addr,
  input  logic [DATA_W-1:0]  i_p1_data,
  input  logic               i_p1_lock,
  output logic               o_p1_ready,
  output logic               o_p1_rvalid,
  output logic [DATA_W-1:0]  o_p1_rdata,
  output logic               o_m_valid,
  output logic               o_m_we,
  output logic [WADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0]  o_m_data,
  input  logic [DATA_W-1:0]  i_m_data
);

  arb_req_t   w_req [2];
  logic [1:0] w_valid;

  req_id_t    r_last,     w_last_nxt;
  req_id_t    r_owner,    w_owner_nxt;
  logic       r_owner_v,  w_owner_v_nxt;
  logic [7:0] r_hold_cnt, w_hold_nxt;
  logic       r_rd_v,     w_rd_v_nxt;
  req_id_t    r_rd_id,    w_rd_id_nxt;

  logic       w_force;
  logic       w_gnt_v;
  req_id_t    w_gnt_id;
  arb_req_t   w_sel;
  logic       w_other_waiting;
  logic [7:0] w_hold_base;

  assign w_req[0] = '{we: i_p0_we, addr: i_p0_addr, data: i_p0_data, lock: i_p0_lock};
  assign w_req[1] = '{we: i_p1_we, addr: i_p1_addr, data: i_p1_data, lock: i_p1_lock};
  assign w_valid  = {i_p1_valid, i_p0_valid};

  // A saturated hold count overrides the lock for exactly one arbitration.
  assign w_force = r_owner_v && (r_hold_cnt >= 8'(MAX_HOLD));

  always_comb begin
    w_gnt_v  = (|w_valid) && !i_rst;
    w_gnt_id = REQ_P0;
    if (w_valid == 2'b11) begin
      if (r_owner_v) w_gnt_id = w_force ? other_req(r_owner) : r_owner;
      else           w_gnt_id = other_req(r_last);
    end else if (w_valid[1]) begin
      w_gnt_id = REQ_P1;
    end
  end

  assign w_sel           = w_req[w_gnt_id];
  assign w_other_waiting = w_valid[other_req(w_gnt_id)];

  always_comb begin
    w_last_nxt    = r_last;
    w_owner_nxt   = r_owner;
    w_owner_v_nxt = r_owner_v;
    w_hold_nxt    = r_hold_cnt;
    w_hold_base   = '0;
    w_rd_v_nxt    = w_gnt_v && !w_sel.we;
    w_rd_id_nxt   = w_gnt_id;
    if (w_gnt_v) begin
      w_last_nxt = w_gnt_id;
      if (w_sel.lock) begin
        w_owner_v_nxt = 1'b1;
        w_owner_nxt   = w_gnt_id;
      end else if ((r_owner_v && (r_owner == w_gnt_id)) || w_force) begin
        w_owner_v_nxt = 1'b0;
      end
      // Count only consecutive grants to an unchanged, unforced owner.
      if (r_owner_v && (r_owner == w_gnt_id) && !w_force) w_hold_base = r_hold_cnt;
      if (!w_owner_v_nxt)                w_hold_nxt = '0;
      else if (w_owner_nxt == w_gnt_id)  w_hold_nxt = w_other_waiting ? sat_inc8(w_hold_base)
                                                                      : w_hold_base;
      else                               w_hold_nxt = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last     <= REQ_P1;
      r_owner    <= REQ_P0;
      r_owner_v  <= 1'b0;
      r_hold_cnt <= '0;
      r_rd_v     <= 1'b0;
      r_rd_id    <= REQ_P0;
    end else begin
      r_last     <= w_last_nxt;
      r_owner    <= w_owner_nxt;
      r_owner_v  <= w_owner_v_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rd_v     <= w_rd_v_nxt;
      r_rd_id    <= w_rd_id_nxt;
    end
  end

  assign o_p0_ready  = w_gnt_v && (w_gnt_id == REQ_P0);
  assign o_p1_ready  = w_gnt_v && (w_gnt_id == REQ_P1);
  assign o_m_valid   = w_gnt_v;
  assign o_m_we      = w_gnt_v && w_sel.we;
  assign o_m_addr    = w_gnt_v ? w_sel.addr : '0;
  assign o_m_data    = w_gnt_v ? w_sel.data : '0;

  assign o_p0_rvalid = r_rd_v && !i_rst && (r_rd_id == REQ_P0);
  assign o_p1_rvalid = r_rd_v && !i_rst && (r_rd_id == REQ_P1);
  assign o_p0_rdata  = i_rst ? '0 : i_m_data;
  assign o_p1_rdata  = i_rst ? '0 : i_m_data;

endmodule
